// File: rtl/vram_wrbuf_ctrl_if.sv
// CPU-side write posting and BBC bus ownership signals of the VRAM write buffer.
// master: CPU address/data latching logic; slave: vram_wrbuf_ctrl.
interface vram_wrbuf_ctrl_if #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 16
);
  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  logic              wr_valid;
  logic [ADDR_W-1:0] wr_adr;
  logic [7:0]        wr_data;
  logic              wr_ready;
  logic              ls_req;
  logic              ls_grant;
  logic              flush_req;
  logic              flush_busy;
  logic              wb_active;
  logic [ADDR_W-1:0] wb_adr;
  logic [7:0]        wb_data;
  logic [CntW-1:0]   wb_count;

  modport master (
    output wr_valid, wr_adr, wr_data, ls_req, flush_req,
    input  wr_ready, ls_grant, flush_busy, wb_active, wb_adr, wb_data, wb_count
  );

  modport slave (
    input  wr_valid, wr_adr, wr_data, ls_req, flush_req,
    output wr_ready, ls_grant, flush_busy, wb_active, wb_adr, wb_data, wb_count
  );
endinterface

// File: rtl/vram_wrbuf_ctrl.sv
// Posted VRAM write buffer: absorbs fast-clock CPU writes and drains them onto the BBC bus,
// one per 2MHz cycle, arbitrating each BBC cycle between the buffer and CPU slow accesses.
module vram_wrbuf_ctrl #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input logic              hsclk,
  input logic              resetb,
  input logic              bbc_phi0,
  vram_wrbuf_ctrl_if.slave bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StIdle, StBufCyc, StCpuCyc} state_e;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q;
  logic                   fall_evt;

  logic [ADDR_W-1:0] adr_mem [DEPTH];
  logic [7:0]        dat_mem [DEPTH];

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] count_after_pop;
  logic            push, pop;

  state_e state_q, state_d;
  logic   wb_active_q, wb_active_d;
  logic   ls_grant_q, ls_grant_d;

  // Falling phi0 marks the start of BBC phi1: the one point where bus ownership may change.
  assign fall_evt = hist_q & ~sync_q[SYNC_STAGES-1];

  assign pop             = fall_evt & (state_q == StBufCyc);
  assign bus.wr_ready    = (count_q < CntW'(DEPTH)) | pop;
  assign push            = bus.wr_valid & bus.wr_ready;
  assign count_after_pop = count_q - CntW'(pop);

  always_comb begin
    sync_d    = sync_q << 1;
    sync_d[0] = bbc_phi0;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
    count_d = count_q + CntW'(push) - CntW'(pop);

    // A push landing with the decision is not counted: its entry waits for the next BBC cycle.
    state_d = state_q;
    if (fall_evt) begin
      if (count_after_pop != '0) begin
        state_d = StBufCyc;
      end else if (bus.ls_req) begin
        state_d = StCpuCyc;
      end else begin
        state_d = StIdle;
      end
    end

    wb_active_d = (state_d == StBufCyc);
    ls_grant_d  = (state_d == StCpuCyc);
  end

  always_ff @(posedge hsclk or negedge resetb) begin
    if (!resetb) begin
      sync_q      <= '0;
      hist_q      <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      state_q     <= StIdle;
      wb_active_q <= 1'b0;
      ls_grant_q  <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      hist_q      <= sync_q[SYNC_STAGES-1];
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      state_q     <= state_d;
      wb_active_q <= wb_active_d;
      ls_grant_q  <= ls_grant_d;
    end
  end

  always_ff @(posedge hsclk) begin
    if (push) begin
      adr_mem[wr_ptr_q] <= bus.wr_adr;
      dat_mem[wr_ptr_q] <= bus.wr_data;
    end
  end

  assign bus.wb_active  = wb_active_q;
  assign bus.ls_grant   = ls_grant_q;
  assign bus.wb_adr     = adr_mem[rd_ptr_q];
  assign bus.wb_data    = dat_mem[rd_ptr_q];
  assign bus.wb_count   = count_q;
  assign bus.flush_busy = bus.flush_req & (count_q != '0);

endmodule
